// File: rtl/bit_cnt_pkg.sv
// Shared types and widths for the bit-count dispatcher: FSM encoding and datapath widths.
package bit_cnt_pkg;

   localparam int DATA_W  = 8;
   localparam int CNT_W   = 4;
   localparam int TOTAL_W = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2,
      OUTPUT    = 2'd3
   } state_t;

endpackage

// File: rtl/bit_cnt_fifo.sv
// Small synchronous FIFO with a combinational head; push/pop are ignored when full/empty.
module bit_cnt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             iclk,
   input  logic             irstn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign o_empty = (count == '0);
   assign o_full  = (count == (AW+1)'(DEPTH));
   assign push_ok = i_push & ~o_full;
   assign pop_ok  = i_pop & ~o_empty;
   assign o_head  = mem[rd_ptr];

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge iclk or negedge irstn) begin
      if (!irstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge iclk) begin
      if (push_ok) mem[wr_ptr] <= i_data;
   end

endmodule

// File: rtl/bit_cnt_dispatcher.sv
// Feeds queued bytes one at a time to an external ones-counter and forwards each result
// downstream, accumulating a running total and flagging counter timeouts.
module bit_cnt_dispatcher
   import bit_cnt_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int BUSY_TMO   = 4,
   parameter int DONE_TMO   = 16
) (
   input  logic               iclk,
   input  logic               irstn,
   input  logic               i_in_valid,
   input  logic [DATA_W-1:0]  i_in_data,
   output logic               o_in_ready,
   output logic               o_cnt_load,
   output logic [DATA_W-1:0]  o_cnt_data,
   input  logic               i_cnt_ready,
   input  logic [CNT_W-1:0]   i_cnt_value,
   output logic               o_res_valid,
   output logic [DATA_W-1:0]  o_res_data,
   output logic [CNT_W-1:0]   o_res_cnt,
   input  logic               i_res_ready,
   output logic [TOTAL_W-1:0] o_total,
   output logic               o_err
);

   localparam int TMO_MAX = (BUSY_TMO > DONE_TMO) ? BUSY_TMO : DONE_TMO;
   localparam int TMO_W   = $clog2(TMO_MAX + 1);

   state_t            state;
   logic [TMO_W-1:0]  tmo;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_empty;
   logic              fifo_full;
   logic              fifo_pop;

   assign o_in_ready = ~fifo_full;
   assign fifo_pop   = (state == IDLE) && !fifo_empty && i_cnt_ready;

   bit_cnt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .iclk    (iclk),
      .irstn   (irstn),
      .i_push  (i_in_valid & o_in_ready),
      .i_data  (i_in_data),
      .i_pop   (fifo_pop),
      .o_head  (fifo_head),
      .o_empty (fifo_empty),
      .o_full  (fifo_full)
   );

   always_ff @(posedge iclk or negedge irstn) begin
      if (!irstn) begin
         state       <= IDLE;
         tmo         <= '0;
         o_cnt_load  <= 1'b0;
         o_cnt_data  <= '0;
         o_res_valid <= 1'b0;
         o_res_data  <= '0;
         o_res_cnt   <= '0;
         o_total     <= '0;
         o_err       <= 1'b0;
      end else begin
         o_cnt_load <= 1'b0;
         case (state)
            IDLE: begin
               if (fifo_pop) begin
                  o_cnt_load <= 1'b1;
                  o_cnt_data <= fifo_head;
                  o_res_data <= fifo_head;
                  tmo        <= '0;
                  state      <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (!i_cnt_ready) begin
                  tmo   <= '0;
                  state <= WAIT_DONE;
               end else if (tmo == TMO_W'(BUSY_TMO - 1)) begin
                  o_err <= 1'b1;
                  state <= IDLE;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            WAIT_DONE: begin
               // i_cnt_value is only meaningful on the first ready cycle, so capture it here.
               if (i_cnt_ready) begin
                  o_res_cnt   <= i_cnt_value;
                  o_res_valid <= 1'b1;
                  state       <= OUTPUT;
               end else if (tmo == TMO_W'(DONE_TMO - 1)) begin
                  o_err <= 1'b1;
                  state <= IDLE;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            OUTPUT: begin
               if (i_res_ready) begin
                  o_res_valid <= 1'b0;
                  o_total     <= o_total + TOTAL_W'(o_res_cnt);
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_cnt_dispatcher.sv
// Directed bench for bit_cnt_dispatcher with a simple ones-counter responder model.
module tb_bit_cnt_dispatcher;

   logic        iclk = 1'b0;
   logic        irstn = 1'b0;
   logic        i_in_valid = 1'b0;
   logic [7:0]  i_in_data = '0;
   logic        o_in_ready;
   logic        o_cnt_load;
   logic [7:0]  o_cnt_data;
   logic        i_cnt_ready;
   logic [3:0]  i_cnt_value;
   logic        o_res_valid;
   logic [7:0]  o_res_data;
   logic [3:0]  o_res_cnt;
   logic        i_res_ready = 1'b1;
   logic [15:0] o_total;
   logic        o_err;

   int total_n = 0;
   int bad_n   = 0;

   int          busy_len = 3;
   logic        stuck = 1'b0;
   int          remain;
   logic [3:0]  pend;
   int          load_cnt = 0;
   logic [7:0]  last_load = '0;
   logic [11:0] res_q [$];

   always #5 iclk = ~iclk;

   bit_cnt_dispatcher #(
      .FIFO_DEPTH (4),
      .BUSY_TMO   (4),
      .DONE_TMO   (16)
   ) dut (
      .iclk        (iclk),
      .irstn       (irstn),
      .i_in_valid  (i_in_valid),
      .i_in_data   (i_in_data),
      .o_in_ready  (o_in_ready),
      .o_cnt_load  (o_cnt_load),
      .o_cnt_data  (o_cnt_data),
      .i_cnt_ready (i_cnt_ready),
      .i_cnt_value (i_cnt_value),
      .o_res_valid (o_res_valid),
      .o_res_data  (o_res_data),
      .o_res_cnt   (o_res_cnt),
      .i_res_ready (i_res_ready),
      .o_total     (o_total),
      .o_err       (o_err)
   );

   // Counter responder: goes busy the edge after a load, result valid for one cycle only.
   always @(posedge iclk or negedge irstn) begin
      if (!irstn) begin
         i_cnt_ready <= 1'b1;
         i_cnt_value <= '0;
         remain      <= 0;
         pend        <= '0;
      end else begin
         i_cnt_value <= '0;
         if (o_cnt_load && !stuck) begin
            i_cnt_ready <= 1'b0;
            remain      <= busy_len;
            pend        <= 4'($countones(o_cnt_data));
         end else if (!i_cnt_ready) begin
            if (remain <= 1) begin
               i_cnt_ready <= 1'b1;
               i_cnt_value <= pend;
            end else begin
               remain <= remain - 1;
            end
         end
      end
   end

   always @(posedge iclk) begin
      if (o_cnt_load) begin
         load_cnt  = load_cnt + 1;
         last_load = o_cnt_data;
      end
      if (o_res_valid && i_res_ready) res_q.push_back({o_res_data, o_res_cnt});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_n++;
      if (obs !== exp) begin
         bad_n++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Leaves i_in_valid high so consecutive calls push back-to-back.
   task automatic push(input logic [7:0] b);
      int n = 0;
      i_in_valid = 1'b1;
      i_in_data  = b;
      while (!o_in_ready && n < 200) begin
         @(negedge iclk);
         n++;
      end
      @(negedge iclk);
      chk("push_accept", 32'(n < 200), 1);
   endtask

   task automatic wait_results(input int cnt);
      int n = 0;
      while (res_q.size() < cnt && n < 400) begin
         @(negedge iclk);
         n++;
      end
      chk("result_count", res_q.size(), cnt);
   endtask

   task automatic do_reset();
      @(negedge iclk);
      irstn = 1'b0;
      repeat (2) @(negedge iclk);
      irstn = 1'b1;
      @(negedge iclk);
      res_q.delete();
      load_cnt = 0;
   endtask

   initial begin
      logic [7:0] bytes2 [5];
      logic [3:0] cnts2 [5];
      int n;
      bytes2 = '{8'hFF, 8'h00, 8'h0F, 8'h80, 8'h01};
      cnts2  = '{4'd8, 4'd0, 4'd4, 4'd1, 4'd1};

      // Reset state
      repeat (2) @(negedge iclk);
      chk("rst_load",  32'(o_cnt_load), 0);
      chk("rst_cdata", 32'(o_cnt_data), 0);
      chk("rst_valid", 32'(o_res_valid), 0);
      chk("rst_rdata", 32'(o_res_data), 0);
      chk("rst_rcnt",  32'(o_res_cnt), 0);
      chk("rst_total", 32'(o_total), 0);
      chk("rst_err",   32'(o_err), 0);
      irstn = 1'b1;
      @(negedge iclk);
      chk("rst_inrdy", 32'(o_in_ready), 1);

      // Single byte 0xA5
      busy_len = 3;
      push(8'hA5);
      i_in_valid = 1'b0;
      wait_results(1);
      chk("a5_loads", load_cnt, 1);
      chk("a5_ldata", 32'(last_load), 32'hA5);
      if (res_q.size() > 0) chk("a5_res", 32'(res_q[0]), {20'd0, 8'hA5, 4'd4});
      chk("a5_total", 32'(o_total), 4);

      // Back-to-back pushes with a slow counter
      do_reset();
      busy_len = 10;
      for (int i = 0; i < 5; i++) push(bytes2[i]);
      i_in_valid = 1'b0;
      chk("b2b_full", 32'(o_in_ready), 0);
      wait_results(5);
      for (int i = 0; i < 5; i++)
         if (i < res_q.size()) chk($sformatf("b2b_res%0d", i), 32'(res_q[i]), {20'd0, bytes2[i], cnts2[i]});
      chk("b2b_total", 32'(o_total), 14);

      // Downstream back-pressure in OUTPUT
      do_reset();
      busy_len = 3;
      i_res_ready = 1'b0;
      push(8'h5A);
      push(8'h07);
      i_in_valid = 1'b0;
      n = 0;
      while (!o_res_valid && n < 100) begin
         @(negedge iclk);
         n++;
      end
      chk("bp_valid_seen", 32'(o_res_valid), 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge iclk);
         chk("bp_hold", {19'd0, o_res_valid, o_res_data, o_res_cnt}, {19'd0, 1'b1, 8'h5A, 4'd4});
         chk("bp_total", 32'(o_total), 0);
      end
      chk("bp_loads", load_cnt, 1);
      i_res_ready = 1'b1;
      wait_results(2);
      if (res_q.size() > 1) begin
         chk("bp_res0", 32'(res_q[0]), {20'd0, 8'h5A, 4'd4});
         chk("bp_res1", 32'(res_q[1]), {20'd0, 8'h07, 4'd3});
      end
      chk("bp_total_end", 32'(o_total), 7);

      // Counter never goes busy -> timeout
      do_reset();
      stuck = 1'b1;
      push(8'h3C);
      i_in_valid = 1'b0;
      n = 0;
      while (!o_err && n < 20) begin
         @(negedge iclk);
         n++;
      end
      chk("tmo_err", 32'(o_err), 1);
      chk("tmo_err_delay", 32'(n >= 3 && n <= 6), 1);
      repeat (3) @(negedge iclk);
      chk("tmo_nores", res_q.size(), 0);
      chk("tmo_valid", 32'(o_res_valid), 0);
      chk("tmo_total", 32'(o_total), 0);
      stuck = 1'b0;
      push(8'h01);
      i_in_valid = 1'b0;
      wait_results(1);
      if (res_q.size() > 0) chk("tmo_next", 32'(res_q[0]), {20'd0, 8'h01, 4'd1});
      chk("tmo_total2", 32'(o_total), 1);
      chk("tmo_sticky", 32'(o_err), 1);

      // Reset during WAIT_DONE with bytes queued
      do_reset();
      busy_len = 10;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      i_in_valid = 1'b0;
      repeat (3) @(negedge iclk);
      #1 irstn = 1'b0;
      #1;
      chk("mid_rst_outs", {o_cnt_load, o_cnt_data, o_res_valid, o_res_data, o_res_cnt, o_err},
          '0);
      chk("mid_rst_total", 32'(o_total), 0);
      @(negedge iclk);
      irstn = 1'b1;
      load_cnt = 0;
      res_q.delete();
      repeat (30) @(negedge iclk);
      chk("mid_rst_nores", res_q.size(), 0);
      chk("mid_rst_noload", load_cnt, 0);
      chk("mid_rst_inrdy", 32'(o_in_ready), 1);
      chk("mid_rst_valid", 32'(o_res_valid), 0);
      chk("mid_rst_total2", 32'(o_total), 0);

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule

// File: doc/bit_cnt_dispatcher.md
BIT_CNT_DISPATCHER -- requirements
Module: bit_cnt_dispatcher

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: input byte FIFO depth, power of two, minimum 2.
REQ-002 Parameter BUSY_TMO, default 4: maximum cycles to wait for the counter to go busy after a load.
REQ-003 Parameter DONE_TMO, default 16: maximum cycles to wait for the counter to complete.
REQ-004 iclk  in  1  clock; all state changes on its rising edge.
REQ-005 irstn  in  1  reset, asynchronous, active-low.
REQ-006 i_in_valid  in  1  upstream byte valid.
REQ-007 i_in_data  in  8  upstream byte.
REQ-008 o_in_ready  out  1  FIFO can accept a byte.
REQ-009 o_cnt_load  out  1  one-cycle load strobe to the ones-counter.
REQ-010 o_cnt_data  out  8  byte presented with o_cnt_load.
REQ-011 i_cnt_ready  in  1  counter idle/done; low while counting.
REQ-012 i_cnt_value  in  4  counter result, valid only in the first cycle i_cnt_ready returns high.
REQ-013 o_res_valid  out  1  result available downstream.
REQ-014 o_res_data  out  8  byte that was counted.
REQ-015 o_res_cnt  out  4  number of 1 bits in o_res_data.
REQ-016 i_res_ready  in  1  downstream accepts the result.
REQ-017 o_total  out  16  running sum of accepted o_res_cnt values.
REQ-018 o_err  out  1  sticky timeout flag.

Function
REQ-019 o_in_ready SHALL equal not-full; a push occurs when i_in_valid and o_in_ready are both high, with no pop-anticipation when full.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Simultaneous push and pop SHALL keep occupancy unchanged. A pop SHALL never occur when the FIFO is empty.
REQ-021 FSM states: IDLE, WAIT_BUSY, WAIT_DONE, OUTPUT.
REQ-022 In IDLE, when the FIFO is not empty and i_cnt_ready=1:
  - assert o_cnt_load for exactly one cycle, with o_cnt_data = FIFO head;
  - pop the head in the same cycle and latch it into o_res_data;
  - go to WAIT_BUSY.
REQ-023 WAIT_BUSY:
  - i_cnt_ready=0 -> WAIT_DONE;
  - BUSY_TMO cycles elapse without that -> set o_err, discard the byte, go to IDLE.
REQ-024 WAIT_DONE:
  - first cycle with i_cnt_ready=1 -> capture i_cnt_value into o_res_cnt, go to OUTPUT;
  - DONE_TMO cycles without that -> set o_err, discard, go to IDLE.
REQ-025 OUTPUT:
  - hold o_res_valid=1 with o_res_data and o_res_cnt stable until i_res_ready=1;
  - on that handshake cycle, o_total <= o_total + o_res_cnt (zero-extended, wraps modulo 2^16) and go to IDLE.
REQ-026 At most one byte SHALL be in flight; no load is issued outside IDLE.
REQ-027 Latency: FIFO non-empty in IDLE with counter ready -> o_cnt_load in the same cycle (registered output, so visible after the next edge). Result appears one cycle after counter completion.
REQ-028 Timeout counters SHALL reset on every state entry. o_err SHALL clear only on reset.
REQ-029 Pushes SHALL continue in every FSM state while the FIFO is not full.

Reset
REQ-030 Asserting irstn low at any time SHALL immediately set:
  - o_cnt_load=0, o_cnt_data=0, o_res_valid=0, o_res_data=0, o_res_cnt=0, o_total=0, o_err=0;
  - FIFO empty, so o_in_ready=1 once reset is released;
  - FSM=IDLE.
  Any in-flight byte is lost.
REQ-031 After reset release, no load SHALL issue until i_cnt_ready is sampled high.

Structure
REQ-032 Shared package bit_cnt_pkg SHALL hold the FSM state encoding, the data width (8), the count width (4), and the total width (16).
REQ-033 The FIFO SHALL be a separate sub-module, bit_cnt_fifo, parameterised by depth and width.

Verification
REQ-034 Single byte 0xA5 with the counter model ready -> one o_cnt_load pulse with data 0xA5; result data=0xA5, cnt=4; o_total=4.
REQ-035 Back-to-back pushes 0xFF, 0x00, 0x0F, 0x80, 0x01 with the counter slow (10-cycle busy):
  - o_in_ready drops when 4 bytes are held;
  - results arrive in order with counts 8, 0, 4, 1, 1;
  - o_total=14.
REQ-036 i_res_ready held low for 10 cycles in OUTPUT -> o_res_valid, data and cnt stay stable; no o_cnt_load; o_total is unchanged until the handshake.
REQ-037 Counter model never drops i_cnt_ready after a load of 0x3C -> o_err=1 after 4 cycles; no result; o_total unchanged; the next byte 0x01 still processes normally with cnt 1.
REQ-038 irstn pulsed low during WAIT_DONE with 2 bytes queued -> all outputs 0, FIFO empty, no result emitted after release.
